// File: rtl/core_ctrl_pkg.sv
// Shared control-transfer types for the MCU core: branch kinds, funct3 codes and
// the branch sequencer state encoding.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JAL    = 2'd1,
    JALR   = 2'd2,
    RSVD   = 2'd3
  } br_kind_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    COMPARE  = 2'd2,
    REDIRECT = 2'd3
  } brc_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Maps funct3 plus comparator flags to {taken, illegal}.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module br_cond_eval
  import core_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = br_eq;
      F3_BNE:  taken = !br_eq;
      F3_BLT:  taken = br_lt;
      F3_BGE:  taken = !br_lt;
      F3_BLTU: taken = br_ltu;
      F3_BGEU: taken = !br_ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: waits for operands, compares, redirects fetch (perf counters under BRANCH_CTRL_PERF_EN).
// Latency: taken branch with operands ready at accept N -> flush at N+1, redir_valid at N+2.
// Backpressure: br_ready only in IDLE; redirect held stable until redir_ready.
module branch_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_kind,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            ops_valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic            br_ltu,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic [XLEN-1:0] link_pc,
  output logic            misalign_exc,
  output logic            illegal_br,
  output logic            wait_timeout
`ifdef BRANCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_br_total,
  output logic [31:0]     perf_br_taken
`endif
);

  // Counter saturates one past WAIT_MAX so the timeout fires only once per wait.
  localparam int            CW       = $clog2(WAIT_MAX + 2);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  brc_state_t      state, state_nxt;
  br_kind_t        kind_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] jalr_sum, target;
  logic            cond_taken, cond_illegal;

  br_cond_eval u_cond (
    .funct3  (f3_q),
    .br_eq   (br_eq),
    .br_lt   (br_lt),
    .br_ltu  (br_ltu),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign jalr_sum = cmp_a + imm_q;
  assign target   = (kind_q == JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      kind_q   <= BRANCH;
      f3_q     <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      redir_pc <= '0;
      link_pc  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (br_valid) begin
            kind_q   <= br_kind_t'(br_kind);
            f3_q     <= funct3;
            pc_q     <= pc;
            imm_q    <= imm;
            cmp_a    <= rs1;
            cmp_b    <= rs2;
            wait_cnt <= '0;
          end
        end
        WAIT_OPS: begin
          cmp_a <= rs1;
          cmp_b <= rs2;
          if (wait_cnt <= WAIT_LIM) wait_cnt <= wait_cnt + 1'b1;
        end
        COMPARE: begin
          if (state_nxt == REDIRECT) begin
            redir_pc <= target;
            link_pc  <= pc_q + XLEN'(4);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    br_ready     = 1'b0;
    redir_valid  = 1'b0;
    flush        = 1'b0;
    misalign_exc = 1'b0;
    illegal_br   = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_nxt = ops_valid ? COMPARE : WAIT_OPS;
      end
      WAIT_OPS: begin
        if (ops_valid) state_nxt = COMPARE;
      end
      COMPARE: begin
        state_nxt = IDLE;
        if (kind_q == RSVD || (kind_q == BRANCH && cond_illegal)) begin
          illegal_br = 1'b1;
        end else if (kind_q != BRANCH || cond_taken) begin
          if (target[1:0] != 2'b00) begin
            misalign_exc = 1'b1;
          end else begin
            flush     = 1'b1;
            state_nxt = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wait_timeout = (WAIT_MAX != 0) && (state == WAIT_OPS) && (wait_cnt == WAIT_LIM);

`ifdef BRANCH_CTRL_PERF_EN
  logic cond_done;
  assign cond_done = (state == COMPARE) && (kind_q == BRANCH) && !cond_illegal;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_br_total <= '0;
      perf_br_taken <= '0;
    end else if (cond_done) begin
      if (perf_br_total != '1) perf_br_total <= perf_br_total + 32'd1;
      if (cond_taken && perf_br_taken != '1) perf_br_taken <= perf_br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases then random ops against a reference model.
module tb_branch_ctrl;

  localparam int WMAX  = 2;
  localparam int R_NT  = 0;
  localparam int R_RED = 1;
  localparam int R_MIS = 2;
  localparam int R_ILL = 3;

  logic        clk, RST_N;
  logic        br_valid, br_ready;
  logic [1:0]  br_kind;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, rs1, rs2, cmp_a, cmp_b;
  logic        ops_valid, br_eq, br_lt, br_ltu;
  logic        redir_valid, redir_ready, flush, misalign_exc, illegal_br, wait_timeout;
  logic [31:0] redir_pc, link_pc;
`ifdef BRANCH_CTRL_PERF_EN
  logic [31:0] perf_br_total, perf_br_taken;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int m_tot = 0;
  int m_tk = 0;

  branch_ctrl #(.XLEN(32), .WAIT_MAX(WMAX)) dut (
    .CLK(clk), .RST_N(RST_N),
    .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind), .funct3(funct3),
    .pc(pc), .imm(imm), .ops_valid(ops_valid), .rs1(rs1), .rs2(rs2),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .link_pc(link_pc), .misalign_exc(misalign_exc),
    .illegal_br(illegal_br), .wait_timeout(wait_timeout)
`ifdef BRANCH_CTRL_PERF_EN
    , .perf_br_total(perf_br_total), .perf_br_taken(perf_br_taken)
`endif
  );

  // Shared comparator sitting outside the sequencer
  assign br_eq  = (cmp_a == cmp_b);
  assign br_lt  = ($signed(cmp_a) < $signed(cmp_b));
  assign br_ltu = (cmp_a < cmp_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] k, input logic [2:0] f,
                                input logic [31:0] p, input logic [31:0] im,
                                input logic [31:0] a, input logic [31:0] b,
                                output int code, output logic [31:0] tgt,
                                output logic [31:0] lnk, output bit cond, output bit legal);
    lnk   = p + 32'd4;
    tgt   = (k == 2'd2) ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    cond  = 1'b1;
    legal = 1'b1;
    if (k == 2'd0) begin
      case (f)
        3'd0: cond = (a == b);
        3'd1: cond = (a != b);
        3'd4: cond = ($signed(a) < $signed(b));
        3'd5: cond = ($signed(a) >= $signed(b));
        3'd6: cond = (a < b);
        3'd7: cond = (a >= b);
        default: legal = 1'b0;
      endcase
    end
    if (k == 2'd3 || !legal) code = R_ILL;
    else if (!cond)          code = R_NT;
    else if (tgt % 4 != 0)   code = R_MIS;
    else                     code = R_RED;
  endfunction

  task automatic junk_inputs();
    br_valid = 1'($urandom_range(0, 1));
    br_kind  = 2'($urandom);
    funct3   = 3'($urandom);
    pc       = $urandom;
    imm      = $urandom;
    rs1      = $urandom;
    rs2      = $urandom;
    ops_valid = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic op(input logic [1:0] k, input logic [2:0] f, input logic [31:0] p,
                    input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                    input int w, input int stall);
    int code, pulses;
    logic [31:0] tgt, lnk;
    bit cond, legal;
    model(k, f, p, im, a, b, code, tgt, lnk, cond, legal);
    chk("idle_ready", {31'd0, br_ready}, 32'd1);
    br_valid = 1'b1; br_kind = k; funct3 = f; pc = p; imm = im;
    ops_valid = (w == 0);
    rs1 = (w == 0) ? a : $urandom;
    rs2 = (w == 0) ? b : $urandom;
    pulses = 0;
    for (int j = 0; j < w; j++) begin
      @(negedge clk);
      chk("wait_ready", {31'd0, br_ready}, 32'd0);
      chk("wait_timeout", {31'd0, wait_timeout}, (j == WMAX) ? 32'd1 : 32'd0);
      pulses += int'(wait_timeout);
      junk_inputs();
      ops_valid = (j == w - 1);
      if (j == w - 1) begin rs1 = a; rs2 = b; end
    end
    if (w > 0) chk("timeout_count", pulses, (w > WMAX) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("cmp_a", cmp_a, a);
    chk("cmp_b", cmp_b, b);
    chk("flush", {31'd0, flush}, (code == R_RED) ? 32'd1 : 32'd0);
    chk("misalign", {31'd0, misalign_exc}, (code == R_MIS) ? 32'd1 : 32'd0);
    chk("illegal", {31'd0, illegal_br}, (code == R_ILL) ? 32'd1 : 32'd0);
    chk("cmp_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("cmp_ready", {31'd0, br_ready}, 32'd0);
    chk("cmp_timeout", {31'd0, wait_timeout}, 32'd0);
    if (k == 2'd0 && legal) begin
      m_tot++;
      if (cond) m_tk++;
    end
    junk_inputs();
    if (code == R_RED) begin
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        chk("redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("redir_pc", redir_pc, tgt);
        chk("link_pc", link_pc, lnk);
        chk("redir_flush", {31'd0, flush}, 32'd0);
        chk("redir_ready_out", {31'd0, br_ready}, 32'd0);
        junk_inputs();
        redir_ready = (s == stall);
      end
    end
    @(negedge clk);
    redir_ready = 1'b0;
    chk("back_ready", {31'd0, br_ready}, 32'd1);
    chk("back_redir", {31'd0, redir_valid}, 32'd0);
`ifdef BRANCH_CTRL_PERF_EN
    chk("perf_total", perf_br_total, m_tot);
    chk("perf_taken", perf_br_taken, m_tk);
`endif
    br_valid = 1'b0;
    ops_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rp, ri, ra, rb;
    RST_N = 1'b0; br_valid = 1'b0; br_kind = 2'd0; funct3 = 3'd0; pc = '0; imm = '0;
    ops_valid = 1'b0; rs1 = '0; rs2 = '0; redir_ready = 1'b0;
    #1;
    chk("rst_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_pulses", {28'd0, flush, misalign_exc, illegal_br, wait_timeout}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_link_pc", link_pc, 32'd0);
    chk("rst_cmp_a", cmp_a, 32'd0);
    chk("rst_cmp_b", cmp_b, 32'd0);
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);

    op(2'd0, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 3);
    op(2'd0, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0);
    op(2'd0, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0);
`ifdef BRANCH_CTRL_PERF_EN
    chk("perf_total_c12", perf_br_total, 32'd3);
    chk("perf_taken_c12", perf_br_taken, 32'd2);
`endif
    op(2'd2, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 0, 0);
    op(2'd2, 3'b000, 32'h300, 32'h0, 32'h201, 32'h0, 0, 1);
    op(2'd0, 3'b001, 32'h100, 32'h20, 32'h7, 32'h7, 4, 0);
    op(2'd0, 3'b010, 32'h100, 32'h20, 32'h7, 32'h7, 0, 0);
    op(2'd3, 3'b000, 32'h100, 32'h20, 32'h7, 32'h7, 1, 0);
    op(2'd1, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 0, 0);

    // Reset while a redirect is pending
    chk("pre_rst_ready", {31'd0, br_ready}, 32'd1);
    br_valid = 1'b1; br_kind = 2'd1; funct3 = 3'd0; pc = 32'h1000; imm = 32'h40;
    ops_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    br_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_redir", {31'd0, redir_valid}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mid_redir", {31'd0, redir_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_mid_pulses", {28'd0, flush, misalign_exc, illegal_br, wait_timeout}, 32'd0);
    m_tot = 0;
    m_tk = 0;
`ifdef BRANCH_CTRL_PERF_EN
    chk("rst_perf_total", perf_br_total, 32'd0);
`endif
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    chk("post_rst_redir", {31'd0, redir_valid}, 32'd0);
    chk("post_rst_pulses", {28'd0, flush, misalign_exc, illegal_br, wait_timeout}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rp = $urandom;
      ri = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) ri[1:0] = 2'b00;
      ra = $urandom;
      rb = ($urandom_range(0, 1) != 0) ? ra : $urandom;
      op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rp, ri, ra, rb,
         $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
